mem_burst_ctrl: RTL and testbench
=================================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, memory address width; the address space is 2^ADDR_W words.
REQ-003 The block SHALL have parameter LEN_W, default 4, burst length field width; beats = cmd_len+1.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  burst command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write data beat offered.
- wr_ready  out  1  write beat consumed.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  read beat consumed.
- rd_data  out  DATA_W  read beat data.
- M_Addr  out  ADDR_W  memory address.
- M_Data  out  DATA_W  memory write data.
- M_blockEnable  out  1  memory access enable.
- M_We  out  1  memory write enable.
- S_Data  in  DATA_W  memory read data, combinational from M_Addr when M_We&M_blockEnable=0.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 The FSM SHALL have the states IDLE, WRITE and READ.
REQ-006 In IDLE, cmd_ready SHALL be 1; all other states SHALL hold cmd_ready at 0.
REQ-007 On a cmd_valid&cmd_ready cycle, the block SHALL load addr=cmd_addr and remaining=cmd_len, then enter WRITE if cmd_write=1, otherwise READ.
REQ-008 In WRITE:
- wr_ready SHALL be 1.
- M_Addr SHALL equal addr and M_Data SHALL equal wr_data.
- M_We and M_blockEnable SHALL both equal wr_valid.
- The memory SHALL be written at the end of each cycle in which wr_valid is high.
REQ-009 On each write beat, addr SHALL increment modulo 2^ADDR_W (0xFF wraps to 0x00); when remaining=0 on that beat, the FSM SHALL return to IDLE, otherwise remaining SHALL decrement.
REQ-010 A write cycle with wr_valid=0 SHALL hold addr and remaining and SHALL not write memory.
REQ-011 In READ:
- M_Addr SHALL equal addr, M_blockEnable SHALL be 1, and M_We SHALL be 0.
- A beat SHALL be captured when the read slot is free, i.e. !rd_valid | rd_ready.
REQ-012 On capture, rd_data SHALL load S_Data and rd_valid SHALL be 1; addr and remaining SHALL then advance as in REQ-009.
REQ-013 A rd_ready cycle with no capture SHALL clear rd_valid; rd_data SHALL hold whenever rd_valid=1 and rd_ready=0.
REQ-014 Outside WRITE and READ, M_We, M_blockEnable and wr_ready SHALL be 0, and M_Addr and M_Data SHALL be 0.
REQ-015 Latency:
- Write: command accepted in cycle N, first memory write no earlier than cycle N+1.
- Read: command accepted in cycle N, first rd_valid high in cycle N+2 when rd_ready was high.
- Throughput is 1 beat/cycle for both directions.
REQ-016 A new command MAY be accepted in IDLE while a final read beat is still pending; the pending beat SHALL be preserved and delivered before any beat of the new burst.
REQ-017 A burst of 16 beats (cmd_len=15) SHALL complete exactly 16 transfers, and cmd_len=0 SHALL perform exactly 1 transfer.

Reset
REQ-018 When reset=0, the block SHALL immediately enter IDLE and force:
- addr=0, remaining=0.
- rd_valid=0, rd_data=0.
- M_We=0, M_blockEnable=0.
- busy=0, wr_ready=0, cmd_ready=1.
REQ-019 Reset asserted mid-burst SHALL abandon the burst; no memory write SHALL occur in the reset cycle, and no beats from the abandoned burst SHALL appear after release.
REQ-020 Reset deassertion SHALL take effect at the next rising edge of clk.

Structure
REQ-021 Package mem_burst_pkg SHALL hold the state enumeration (IDLE/WRITE/READ) and the default width constants DATA_W, ADDR_W and LEN_W.
REQ-022 The one-entry read output register (rd_valid/rd_data with free-slot logic) SHALL be a sub-module named mem_rd_slot; all other logic SHALL stay in mem_burst_ctrl.

Verification
REQ-023 Write burst: cmd_write=1, cmd_addr=0x10, cmd_len=3, with data 0xA0..0xA3 and wr_valid high continuously -> memory holds 0x10..0x13=0xA0..0xA3, busy is high for 4 cycles, and the block returns to IDLE.
REQ-024 Read burst: read cmd_addr=0x10, cmd_len=3, with rd_ready held high -> rd_data reads 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, and the first beat appears 2 cycles after acceptance.
REQ-025 Wrap-around: write cmd_addr=0xFE, cmd_len=3 with 0x11..0x14 -> addresses 0xFE,0xFF,0x00,0x01 are written; reading them back returns the same data.
REQ-026 Backpressure and gaps:
- Read with rd_ready toggling 1,0,0,1,... -> no beat is lost or duplicated, and rd_data is stable while stalled.
- Write with a wr_valid gap -> M_We=0 during the gap.
REQ-027 Reset mid-burst: assert reset during beat 2 of an 8-beat write -> only beats 0-1 are written, all outputs are at reset values, and a subsequent read burst is correct.
REQ-028 Back-to-back: a read with cmd_len=0 and rd_ready=0, then a second read issued -> the first beat is delivered before the second, each exactly once.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// ----------------------------------------------------------------------------
// mem_burst_pkg
// Shared definitions for the burst memory controller.
//   state_t : controller FSM states (IDLE / WRITE / READ)
//   DATA_W  : default memory data width
//   ADDR_W  : default memory address width (address space is 2^ADDR_W words)
//   LEN_W   : default burst length field width (beats = len + 1)
// ----------------------------------------------------------------------------
package mem_burst_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_rd_slot.sv
// ----------------------------------------------------------------------------
// mem_rd_slot
// One-entry output register for read beats. A beat may be loaded whenever the
// slot is free (empty, or being drained this cycle), giving full throughput
// while holding data steady under backpressure.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   capture   in   load cap_data into the slot this cycle
//   cap_data  in   DATA_W  data to load
//   rd_ready  in   consumer takes the current beat
//   rd_valid  out  slot holds a beat
//   rd_data   out  DATA_W  beat held in the slot
//   slot_free out  slot can accept a new beat this cycle
// ----------------------------------------------------------------------------
module mem_rd_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              slot_free
);

    assign slot_free = !rd_valid || rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (capture) begin
            rd_valid <= 1'b1;
            rd_data  <= cap_data;
        end else if (rd_ready) begin
            // Beat consumed with nothing new behind it; data is left as is
            // since it is only meaningful while rd_valid is high.
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// ----------------------------------------------------------------------------
// mem_burst_ctrl
// Burst controller between a command/stream interface and a single-port
// synchronous-write, combinational-read memory. A command starts a burst of
// cmd_len+1 beats at cmd_addr; addresses increment and wrap modulo 2^ADDR_W.
// Write beats are passed straight to the memory at one beat per cycle; read
// beats are staged through a one-entry output slot (mem_rd_slot).
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   cmd_valid      in   burst command offered
//   cmd_ready      out  command accepted (high only in IDLE)
//   cmd_write      in   1 = write burst, 0 = read burst
//   cmd_addr       in   ADDR_W  start address
//   cmd_len        in   LEN_W   beats minus one
//   wr_valid       in   write beat offered
//   wr_ready       out  write beat consumed
//   wr_data        in   DATA_W  write beat data
//   rd_valid       out  read beat available
//   rd_ready       in   read beat consumed
//   rd_data        out  DATA_W  read beat data
//   M_Addr         out  ADDR_W  memory address
//   M_Data         out  DATA_W  memory write data
//   M_blockEnable  out  memory access enable
//   M_We           out  memory write enable
//   S_Data         in   DATA_W  memory read data (combinational from M_Addr)
//   busy           out  burst in progress (state not IDLE)
// ----------------------------------------------------------------------------
module mem_burst_ctrl #(
    parameter int DATA_W = mem_burst_pkg::DATA_W,
    parameter int ADDR_W = mem_burst_pkg::ADDR_W,
    parameter int LEN_W  = mem_burst_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] M_Addr,
    output logic [DATA_W-1:0] M_Data,
    output logic              M_blockEnable,
    output logic              M_We,
    input  logic [DATA_W-1:0] S_Data,
    output logic              busy
);

    import mem_burst_pkg::*;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;

    logic cmd_accept;
    logic slot_free;
    logic capture;
    logic wr_beat;
    logic beat;
    logic last_beat;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign wr_beat    = (state == WRITE) && wr_valid;
    // A read beat is taken from memory only when the output slot can hold it,
    // so the memory address never advances past an undelivered beat.
    assign capture    = (state == READ) && slot_free;
    assign beat       = wr_beat || capture;
    assign last_beat  = beat && (remaining == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_nx = cmd_write ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (last_beat) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Burst address and beat counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (cmd_accept) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
        end else if (beat) begin
            addr <= addr + ADDR_W'(1);
            if (remaining != '0) begin
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        M_Addr        = '0;
        M_Data        = '0;
        M_blockEnable = 1'b0;
        M_We          = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            WRITE: begin
                wr_ready      = 1'b1;
                M_Addr        = addr;
                M_Data        = wr_data;
                M_We          = wr_valid;
                M_blockEnable = wr_valid;
            end
            READ: begin
                M_Addr        = addr;
                M_blockEnable = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    mem_rd_slot #(
        .DATA_W (DATA_W)
    ) u_rd_slot (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .cap_data  (S_Data),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_burst_ctrl
// Bench for mem_burst_ctrl: behavioural memory attached to the M_/S_ port,
// expected write beats and read beats queued when stimulus is issued and
// compared as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_len = 4'h0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [7:0] M_Addr;
    logic [7:0] M_Data;
    logic       M_blockEnable;
    logic       M_We;
    logic [7:0] S_Data;
    logic       busy;

    logic [7:0]  mem     [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rd_mode = 0;
    int ph = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    mem_burst_ctrl #(.DATA_W(8), .ADDR_W(8), .LEN_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .M_blockEnable (M_blockEnable),
        .M_We          (M_We),
        .S_Data        (S_Data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (M_We && M_blockEnable) mem[M_Addr] <= M_Data;
    end
    assign S_Data = mem[M_Addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // rd_ready pattern: 0 = held low, 1 = held high, 2 = 1,0,0 repeating
    always @(posedge clk) begin
        #1;
        ph = ph + 1;
        case (rd_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = ((ph % 3) == 0);
        endcase
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_stall) begin
                chk("rd_hold_valid", rd_valid, 1'b1);
                chk("rd_hold_data", rd_data, prev_data);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (rd_valid && rd_ready) begin
                rd_cnt++;
                if (rd_q.size() == 0) chk("rd_beat_expected", rd_q.size(), 1);
                else chk("rd_data", rd_data, rd_q.pop_front());
            end
            if (M_We && M_blockEnable) begin
                wr_cnt++;
                if (wr_q.size() == 0) chk("wr_beat_expected", wr_q.size(), 1);
                else begin
                    logic [15:0] e;
                    e = wr_q.pop_front();
                    chk("wr_addr", M_Addr, e[15:8]);
                    chk("wr_data", M_Data, e[7:0]);
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1
    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] l);
        int t;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_beat(input logic [7:0] ad, input logic [7:0] d);
        wr_valid = 1'b1; wr_data = d;
        wr_q.push_back({ad, d});
        ref_mem[ad] = d;
        @(negedge clk);
        chk("wr_ready", wr_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [3:0] l,
                               input logic [7:0] d0, input bit gap);
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (gap && i == 2) begin
                wr_valid = 1'b0;
                @(negedge clk);
                chk("gap_we", M_We, 1'b0);
                chk("gap_en", M_blockEnable, 1'b0);
                @(posedge clk); #1;
            end
            write_beat(a + 8'(i), d0 + 8'(i));
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [3:0] l);
        for (int i = 0; i <= int'(l); i++) rd_q.push_back(ref_mem[a + 8'(i)]);
        send_cmd(1'b0, a, l);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rd_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", t < 300, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_we", M_We, 1'b0);
        chk("rst_en", M_blockEnable, 1'b0);
        chk("rst_maddr", M_Addr, 8'h00);
        reset = 1'b1;
        rd_mode = 1;
        @(posedge clk); #1;

        // Write burst 0x10, 4 beats
        busy_cnt = 0;
        write_burst(8'h10, 4'd3, 8'hA0, 1'b0);
        chk("wr_busy_cycles", busy_cnt, 4);
        chk("wr_idle_after", busy, 1'b0);
        chk("wr_mem_13", mem[8'h13], 8'hA3);

        // Read burst 0x10 with rd_ready high: latency and back-to-back beats
        read_burst(8'h10, 4'd3);
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!rd_valid && t < 20);
            chk("rd_latency", cyc - acc_cyc, 2);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("rd_consecutive", rd_valid, 1'b1);
            end
        end
        @(posedge clk); #1;
        drain();

        // Address wrap
        write_burst(8'hFE, 4'd3, 8'h11, 1'b0);
        chk("wrap_mem_ff", mem[8'hFF], 8'h12);
        chk("wrap_mem_00", mem[8'h00], 8'h13);
        read_burst(8'hFE, 4'd3);
        drain();

        // Read with backpressure 1,0,0 pattern
        rd_mode = 2;
        read_burst(8'h10, 4'd3);
        drain();
        rd_mode = 1;

        // Write with a wr_valid gap, then read back
        write_burst(8'h40, 4'd3, 8'h60, 1'b1);
        read_burst(8'h40, 4'd3);
        drain();

        // 16-beat burst
        wr_cnt = 0;
        write_burst(8'h20, 4'd15, 8'h50, 1'b0);
        chk("len16_wr_count", wr_cnt, 16);
        rd_cnt = 0;
        read_burst(8'h20, 4'd15);
        drain();
        chk("len16_rd_count", rd_cnt, 16);

        // Reset during beat 2 of an 8-beat write
        send_cmd(1'b1, 8'h80, 4'd7);
        write_beat(8'h80, 8'hC0);
        write_beat(8'h81, 8'hC1);
        wr_valid = 1'b1; wr_data = 8'hC2;
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_we", M_We, 1'b0);
        chk("mid_rst_en", M_blockEnable, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_wr_ready", wr_ready, 1'b0);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_maddr", M_Addr, 8'h00);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        reset = 1'b1;
        chk("mid_rst_no_write", mem[8'h82], 8'h00);
        chk("mid_rst_beat1", mem[8'h81], 8'hC1);
        chk("mid_rst_wr_pending", wr_q.size(), 0);
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 1'b0);
        read_burst(8'h80, 4'd3);
        drain();

        // Back-to-back single-beat reads with the first beat stalled
        rd_mode = 0;
        @(posedge clk); #1;
        read_burst(8'h10, 4'd0);
        begin
            int t;
            t = 0;
            while (!rd_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_first_valid", rd_valid, 1'b1);
        end
        @(posedge clk); #1;
        read_burst(8'h11, 4'd0);
        repeat (3) @(negedge clk);
        chk("b2b_hold_data", rd_data, ref_mem[8'h10]);
        chk("b2b_second_waiting", busy, 1'b1);
        @(posedge clk); #1;
        rd_mode = 1;
        drain();
        chk("b2b_rd_pending", rd_q.size(), 0);
        chk("b2b_slot_empty", rd_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
